// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 4-bit write-only controller: power-up wait, init sequence, then byte writes.
// Define LCD_AUTO_WRAP_EN to add cursor tracking with automatic line-wrap commands.
module lcd_hd44780_ctrl #(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_EN    = 25,
  parameter int unsigned T_NIB   = 50,
  parameter int unsigned T_CMD   = 2500,
  parameter int unsigned T_CLR   = 100000,
  parameter int unsigned COLS    = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic       in_rs_i,
  input  logic [7:0] in_data_i,
  output logic       init_done_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_e_o,
  output logic [3:0] lcd_d_o
);

  localparam int unsigned Max1   = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
  localparam int unsigned Max2   = (T_CMD > T_EN) ? T_CMD : T_EN;
  localparam int unsigned Max3   = (Max2 > T_NIB) ? Max2 : T_NIB;
  localparam int unsigned CntMax = (Max1 > Max3) ? Max1 : Max3;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StPwrup, StIdle, StSetup, StEHi, StHold, StWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      byte_q, byte_d;
  logic            rs_q, rs_d, low_q, low_d, single_q, single_d;
  logic            init_q, init_d, done_q, done_d;
  logic [2:0]      step_q, step_d;

  logic            load, load_rs, load_single, load_wrap, wrap_pend, wrap_line;
  logic [7:0]      load_byte;
  logic [CntW-1:0] wait_last;

  // Init sequence: steps 0..3 are single nibbles (high half of the byte), 4..7 full bytes.
  function automatic logic [7:0] init_cmd(input logic [2:0] step);
    case (step)
      3'd0, 3'd1, 3'd2: init_cmd = 8'h30;
      3'd3:             init_cmd = 8'h20;
      3'd4:             init_cmd = 8'h28;
      3'd5:             init_cmd = 8'h0C;
      3'd6:             init_cmd = 8'h01;
      default:          init_cmd = 8'h06;
    endcase
  endfunction

  assign wait_last = (single_q || (!rs_q && byte_q[7:1] == 7'd0)) ? CntW'(T_CLR - 1)
                                                                  : CntW'(T_CMD - 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    byte_d      = byte_q;
    rs_d        = rs_q;
    low_d       = low_q;
    single_d    = single_q;
    init_d      = init_q;
    done_d      = done_q;
    step_d      = step_q;
    load        = 1'b0;
    load_byte   = byte_q;
    load_rs     = rs_q;
    load_single = 1'b0;
    load_wrap   = 1'b0;
    unique case (state_q)
      StPwrup: if (cnt_q == CntW'(T_PWRUP - 1)) begin
        load        = 1'b1;
        load_byte   = init_cmd(3'd0);
        load_rs     = 1'b0;
        load_single = 1'b1;
        step_d      = 3'd0;
        init_d      = 1'b1;
        state_d     = StSetup;
      end
      StIdle: begin
        cnt_d = '0;
        if (in_valid_i && done_q) begin
          load      = 1'b1;
          load_byte = in_data_i;
          load_rs   = in_rs_i;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StEHi;
      end
      StEHi: if (cnt_q == CntW'(T_EN - 1)) begin
        cnt_d   = '0;
        state_d = StHold;
      end
      StHold: if (cnt_q == CntW'(T_NIB - 1)) begin
        cnt_d = '0;
        if (!low_q && !single_q) begin
          low_d   = 1'b1;
          state_d = StSetup;
        end else begin
          state_d = StWait;
        end
      end
      StWait: if (cnt_q == wait_last) begin
        cnt_d = '0;
        if (init_q && step_q != 3'd7) begin
          load        = 1'b1;
          load_byte   = init_cmd(3'(step_q + 3'd1));
          load_rs     = 1'b0;
          load_single = (step_q < 3'd3);
          step_d      = 3'(step_q + 3'd1);
          state_d     = StSetup;
        end else if (init_q) begin
          init_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (wrap_pend) begin
          load      = 1'b1;
          load_byte = wrap_line ? 8'h80 : 8'hC0;
          load_rs   = 1'b0;
          load_wrap = 1'b1;
          state_d   = StSetup;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StPwrup;
    endcase
    if (load) begin
      byte_d   = load_byte;
      rs_d     = load_rs;
      low_d    = 1'b0;
      single_d = load_single;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StPwrup;
      cnt_q    <= '0;
      byte_q   <= '0;
      rs_q     <= 1'b0;
      low_q    <= 1'b0;
      single_q <= 1'b0;
      init_q   <= 1'b0;
      done_q   <= 1'b0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      rs_q     <= rs_d;
      low_q    <= low_d;
      single_q <= single_d;
      init_q   <= init_d;
      done_q   <= done_d;
      step_q   <= step_d;
    end
  end

`ifdef LCD_AUTO_WRAP_EN
  logic       line_q, line_d, pend_q, pend_d;
  logic [5:0] col_q, col_d;

  // Cursor moves are decoded from whatever byte gets loaded, including the wrap command itself.
  always_comb begin
    line_d = line_q;
    col_d  = col_q;
    pend_d = pend_q;
    if (load && load_rs) begin
      if (col_q == 6'(COLS - 1)) pend_d = 1'b1;
      col_d = col_q + 6'd1;
    end else if (load && !load_single) begin
      if (load_byte[7:1] == 7'd0) begin
        line_d = 1'b0;
        col_d  = '0;
      end else if (load_byte[7]) begin
        line_d = load_byte[6];
        col_d  = load_byte[5:0];
      end
    end
    if (load_wrap) pend_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_q <= 1'b0;
      col_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      line_q <= line_d;
      col_q  <= col_d;
      pend_q <= pend_d;
    end
  end

  assign wrap_pend = pend_q;
  assign wrap_line = line_q;
`else
  assign wrap_pend = 1'b0;
  assign wrap_line = 1'b0;
`endif

  assign in_ready_o  = (state_q == StIdle) && done_q;
  assign init_done_o = done_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_e_o     = (state_q == StEHi);
  assign lcd_d_o     = low_q ? byte_q[3:0] : byte_q[7:4];

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl: observes lcd_e pulses and compares against a transaction model.
module tb_lcd_hd44780_ctrl;
  localparam int unsigned TPwrup = 100;
  localparam int unsigned TEn    = 2;
  localparam int unsigned TNib   = 3;
  localparam int unsigned TCmd   = 10;
  localparam int unsigned TClr   = 40;
  localparam int unsigned Cols   = 16;
  localparam int unsigned Nib    = 1 + TEn + TNib;

  logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_rs = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, init_done, lcd_rs, lcd_rw, lcd_e;
  logic [3:0] lcd_d;

  always #5 clk = ~clk;

  lcd_hd44780_ctrl #(
    .T_PWRUP(TPwrup), .T_EN(TEn), .T_NIB(TNib), .T_CMD(TCmd), .T_CLR(TClr), .COLS(Cols)
  ) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_rs_i(in_rs), .in_data_i(in_data), .init_done_o(init_done),
    .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw), .lcd_e_o(lcd_e), .lcd_d_o(lcd_d)
  );

  int n_tests = 0, n_fail = 0;
  logic [4:0] nib_q[$];
  int width_q[$];
  int e_cnt = 0, hold_err = 0;
  logic e_prev = 1'b0;
  logic [4:0] cur = '0;
  int m_col = 0;
  bit m_line = 1'b0;

  // Pulse monitor: captures {rs,d} at each lcd_e rise, its width, and rs/d stability.
  always @(negedge clk) begin
    if (lcd_e && !e_prev) begin
      nib_q.push_back({lcd_rs, lcd_d});
      cur   <= {lcd_rs, lcd_d};
      e_cnt <= 1;
    end else if (lcd_e) begin
      e_cnt <= e_cnt + 1;
    end else if (e_prev) begin
      width_q.push_back(e_cnt);
    end
    if (!rst && e_prev && {lcd_rs, lcd_d} !== cur) hold_err <= hold_err + 1;
    e_prev <= lcd_e;
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (lcd_e !== 1'b0) begin n_fail++; $display("FAIL reset_e got %b want 0", lcd_e); end
    n_tests++; if ({lcd_rs, lcd_d} !== 5'd0) begin
      n_fail++; $display("FAIL reset_rs_d got %h want 00", {lcd_rs, lcd_d}); end
    n_tests++; if (in_ready !== 1'b0 || init_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got rdy=%b done=%b want 0 0", in_ready, init_done); end
    n_tests++; if (lcd_rw !== 1'b0) begin n_fail++; $display("FAIL reset_rw got %b want 0", lcd_rw); end
  endtask

  task automatic test_init(input string name);
    logic [7:0] single[4] = '{8'h3, 8'h3, 8'h3, 8'h2};
    logic [7:0] cmds[4]   = '{8'h28, 8'h0C, 8'h01, 8'h06};
    logic [4:0] exp[$];
    int exp_cyc, n, bad;
    exp_cyc = TPwrup;
    foreach (single[i]) begin exp.push_back({1'b0, single[i][3:0]}); exp_cyc += Nib + TClr; end
    foreach (cmds[i]) begin
      exp.push_back({1'b0, cmds[i][7:4]});
      exp.push_back({1'b0, cmds[i][3:0]});
      exp_cyc += 2 * Nib + ((cmds[i][7:1] == 7'd0) ? TClr : TCmd);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    nib_q.delete(); width_q.delete(); m_col = 0; m_line = 1'b0;
    rst = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!init_done && n < 5000);
    n_tests++; if (n != exp_cyc) begin
      n_fail++; $display("FAIL %s_cycles got %0d want %0d", name, n, exp_cyc); end
    n_tests++; if (nib_q.size() != exp.size()) begin
      n_fail++; $display("FAIL %s_pulses got %0d want %0d", name, nib_q.size(), exp.size()); end
    bad = 0;
    foreach (exp[i]) if (i >= nib_q.size() || nib_q[i] !== exp[i]) bad++;
    n_tests++; if (bad != 0) begin
      n_fail++; $display("FAIL %s_nibbles got %0d wrong want 0", name, bad); end
    n_tests++; if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_ready got %b want 1", name, in_ready); end
  endtask

  task automatic send(input bit rs, input logic [7:0] d, input string name);
    logic [4:0] exp[$];
    logic [7:0] wcmd;
    int exp_busy, n, base, bad;
    bit clr;
    clr = !rs && d[7:1] == 7'd0;
    exp.push_back({rs, d[7:4]});
    exp.push_back({rs, d[3:0]});
    exp_busy = 2 * Nib + (clr ? TClr : TCmd);
`ifdef LCD_AUTO_WRAP_EN
    if (rs) begin
      if (m_col == Cols - 1) begin
        wcmd = m_line ? 8'h80 : 8'hC0;
        exp.push_back({1'b0, wcmd[7:4]});
        exp.push_back({1'b0, wcmd[3:0]});
        exp_busy += 2 * Nib + TCmd;
        m_line = !m_line;
        m_col = 0;
      end else begin
        m_col++;
      end
    end else if (clr) begin
      m_col = 0; m_line = 1'b0;
    end else if (d[7]) begin
      m_line = d[6]; m_col = int'(d[5:0]);
    end
`else
    wcmd = 8'h00;
`endif
    n = 0;
    while (!in_ready && n < 2000) begin @(posedge clk); #1; n++; end
    base = nib_q.size();
    in_valid = 1'b1; in_rs = rs; in_data = d;
    @(posedge clk); #1;
    in_data = 8'($urandom); in_rs = 1'($urandom);
    n = 0;
    while (!in_ready && n < 2000) begin n++; @(posedge clk); #1; end
    in_valid = 1'b0;
    n_tests++; if (n != exp_busy) begin
      n_fail++; $display("FAIL %s_busy got %0d want %0d", name, n, exp_busy); end
    n_tests++; if (nib_q.size() - base != exp.size()) begin
      n_fail++; $display("FAIL %s_pulses got %0d want %0d", name, nib_q.size() - base, exp.size());
    end
    bad = 0;
    foreach (exp[i]) if (base + i >= nib_q.size() || nib_q[base + i] !== exp[i]) bad++;
    n_tests++; if (bad != 0) begin
      n_fail++; $display("FAIL %s_nibbles got %0d wrong want 0", name, bad); end
  endtask

  task automatic test_widths(input string name);
    int bad = 0;
    foreach (width_q[i]) if (width_q[i] != TEn) bad++;
    n_tests++; if (bad != 0 || hold_err != 0) begin
      n_fail++; $display("FAIL %s_e_width got %0d bad widths %0d hold errs want 0", name, bad, hold_err);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit rs;
    for (int i = 0; i < 20; i++) begin
      rs = 1'($urandom);
      d = 8'($urandom);
      if (!rs) begin
        case ($urandom_range(0, 3))
          0: d = 8'h01;
          1: d = 8'h02;
          2: d = {1'b1, 1'($urandom), 2'b00, 4'($urandom)};
          default: d = {1'b0, d[6:0]};
        endcase
      end
      send(rs, d, "random");
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 33; i++) send(1'b1, 8'($urandom_range(8'h20, 8'h7E)), "wrap");
  endtask

  task automatic test_reset_mid();
    int n = 0, base;
    while (!in_ready && n < 2000) begin @(posedge clk); #1; n++; end
    base = nib_q.size();
    in_valid = 1'b1; in_rs = 1'b0; in_data = 8'h01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (nib_q.size() < base + 2 && n < 200) begin @(negedge clk); n++; end
    #1;
    n_tests++; if (lcd_e !== 1'b1) begin
      n_fail++; $display("FAIL midrst_in_ehi got %b want 1", lcd_e); end
    rst = 1'b1;
    #1;
    n_tests++; if (lcd_e !== 1'b0 || init_done !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_abort got e=%b done=%b rdy=%b want 0 0 0",
                         lcd_e, init_done, in_ready);
    end
    test_init("reinit");
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_widths("init");
    send(1'b1, 8'h48, "data48");
    send(1'b0, 8'h01, "clear");
    send(1'b0, 8'h02, "home");
    send(1'b0, 8'h80, "setpos");
    test_random();
    test_wrap();
    test_widths("traffic");
    test_reset_mid();
    send(1'b1, 8'($urandom), "post_reset");
    test_widths("final");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_hd44780_ctrl.md
LCD_HD44780_CTRL -- requirements
Module: lcd_hd44780_ctrl

Interface
REQ-001 Parameter T_PWRUP, default 750000, SHALL set the power-up wait in clk cycles (15 ms at 50 MHz).
REQ-002 Parameter T_EN, default 25, SHALL set the lcd_e high width in cycles.
REQ-003 Parameter T_NIB, default 50, SHALL set the post-pulse hold cycles per nibble, with lcd_e low and lcd_rs/lcd_d held.
REQ-004 Parameter T_CMD, default 2500, SHALL set the wait after a normal byte.
REQ-005 Parameter T_CLR, default 100000, SHALL set the wait after clear/home and after each init nibble.
REQ-006 Parameter COLS, default 16, SHALL set the columns per line (used only when wrap is enabled).
REQ-007 clk  in  1  SHALL be the single clock, rising edge.
REQ-008 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-009 in_valid  in  1  SHALL indicate that a request is present.
REQ-010 in_ready  out  1  SHALL indicate that the block accepts a request this cycle.
REQ-011 in_rs  in  1  SHALL select the byte type: 0 = command, 1 = data.
REQ-012 in_data  in  8  SHALL carry the byte to write.
REQ-013 init_done  out  1  SHALL be high once the init sequence has completed.
REQ-014 lcd_rs, lcd_rw, lcd_e  out  1 each  SHALL drive the LCD control pins; lcd_rw SHALL be constant 0.
REQ-015 lcd_d  out  4  SHALL drive LCD DB7..DB4.

Function
REQ-016 A transfer SHALL occur on a cycle with in_valid=1 and in_ready=1, and only then; in_valid while in_ready=0 SHALL be ignored.
REQ-017 in_ready SHALL be 1 only in IDLE with init_done=1.
REQ-018 A nibble phase SHALL be SETUP (1 cycle, lcd_e=0, rs/data valid), then E_HI (T_EN cycles, lcd_e=1), then HOLD (T_NIB cycles, lcd_e=0, rs/data unchanged).
REQ-019 A byte SHALL be sent as the high-nibble phase, then the low-nibble phase, then WAIT, then IDLE.
REQ-020 WAIT SHALL last T_CLR cycles for a command with in_data[7:1]=7'b0000000 (clear/home), and T_CMD cycles otherwise.
REQ-021 in_ready SHALL be low for exactly 2*(1+T_EN+T_NIB)+WAIT cycles after the accept cycle.
REQ-022 The request byte and rs SHALL be registered at accept; later input changes SHALL have no effect.
REQ-023 State sequence: PWRUP -> INIT -> IDLE <-> (SETUP -> E_HI -> HOLD) x2 -> WAIT -> IDLE.
REQ-024 PWRUP SHALL count T_PWRUP cycles after reset release.
REQ-025 INIT SHALL send these single-nibble commands, each followed by a T_CLR wait: 0x3, 0x3, 0x3, 0x2.
REQ-026 INIT SHALL then send these full command bytes with REQ-020 waits: 0x28, 0x0C, 0x01, 0x06.
REQ-027 init_done SHALL rise on the cycle IDLE is first entered (12 lcd_e pulses total), and SHALL stay high until reset.
REQ-028 Wait counters SHALL be wide enough for max(T_PWRUP, T_CLR) with no wrap-around.

Reset
REQ-029 While rst=1, lcd_rs, lcd_e, lcd_d, in_ready and init_done SHALL be 0 and the state SHALL be PWRUP with counters cleared.
REQ-030 Reset asserted mid-transfer or mid-init SHALL abort immediately; after release the full PWRUP+INIT sequence SHALL repeat.

Configuration
REQ-031 Macro LCD_AUTO_WRAP_EN, when defined, SHALL enable a cursor tracker of line (1 bit) and col (0..COLS-1), cleared by reset and by the init clear.
REQ-032 With the macro, an accepted data byte SHALL increment col.
REQ-033 With the macro, a data byte written at col=COLS-1 SHALL be followed automatically, after its WAIT, by a command: 0xC0 on line 0 or 0x80 on line 1.
REQ-034 The auto-inserted command SHALL toggle line and set col to 0; in_ready SHALL stay low until its WAIT ends.
REQ-035 With the macro, a clear/home command SHALL zero line and col, and a command with bit7=1 SHALL load line=in_data[6] and col=in_data[5:0].
REQ-036 Without the macro, the tracker SHALL be absent and no command SHALL ever be inserted.

Verification (sim params T_PWRUP=100, T_EN=2, T_NIB=3, T_CMD=10, T_CLR=40, COLS=16)
REQ-037 Reset release, no input -> 12 lcd_e pulses with nibbles 3,3,3,2,2,8,0,C,0,1,0,6; init_done=1 after the last wait.
REQ-038 Accept rs=1, data 0x48 -> nibbles 4 then 8 with lcd_rs=1, each lcd_e high 2 cycles; in_ready low 22 cycles.
REQ-039 Accept rs=0, data 0x01 -> in_ready low 52 cycles; in_valid held high during busy -> no second accept.
REQ-040 rst pulsed during the E_HI of the low nibble -> lcd_e=0 immediately, init_done=0, full init repeats.
REQ-041 Macro on: 16 data bytes -> extra nibbles C,0 after the 16th; 16 more -> nibbles 8,0; macro off -> none.
